// File: rtl/impl_ram_dma_pkg.sv
// impl_ram_dma_pkg
// Shared types and constants for the RAM DMA engine.
//   state_e   : engine FSM states (IDLE, RD, WR, DONE)
//   MODE_*    : transfer mode encodings for mode_i
//   BE_FULL   : byte-enable pattern used for every write
`timescale 1ns/1ps
package impl_ram_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic       MODE_COPY = 1'b0;
  localparam logic       MODE_FILL = 1'b1;
  localparam logic [3:0] BE_FULL   = 4'hF;

endpackage

// File: rtl/impl_ram_dma_if.sv
// impl_ram_dma_if
// One port of the dual-port implementation RAM.
//   en    : port enable
//   addr  : byte address (word aligned)
//   wdata : write data
//   we    : write enable (read when en=1, we=0)
//   be    : byte enables
//   rdata : read data, valid the cycle after an enabled read
// Handshake: there is no valid/ready pair. A request is issued in every
// cycle with en=1; the RAM always accepts it. Read data for a read issued
// in cycle N is presented on rdata during cycle N+1.
// Modports: master = DMA side, slave = RAM side.
`timescale 1ns/1ps
interface impl_ram_dma_if #(
  parameter int ADDR_WIDTH = 22
) ();
  logic                  en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic                  we;
  logic [3:0]            be;
  logic [31:0]           rdata;

  modport master (output en, addr, wdata, we, be, input rdata);
  modport slave  (input en, addr, wdata, we, be, output rdata);
endinterface

// File: rtl/impl_ram_dma.sv
// impl_ram_dma
// Initiator-side block engine for one port of the implementation RAM.
// Copies (src -> dst) or fills (fill pattern -> dst) a block of 32-bit words.
// Ports:
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   start_i            : one-cycle request, sampled only in IDLE
//   mode_i             : MODE_COPY / MODE_FILL
//   src_addr_i         : source byte address (word aligned in copy mode)
//   dst_addr_i         : destination byte address (word aligned)
//   len_i              : number of words
//   fill_data_i        : fill pattern
//   busy_o             : accepted start through DONE
//   done_o             : one-cycle completion/abort pulse
//   err_o              : sticky misalignment flag, cleared on next start
//   csum_o             : XOR of all words written by the last transfer
//   dbg_state_o        : current FSM state
//   ram                : RAM port (master side)
`timescale 1ns/1ps
module impl_ram_dma
  import impl_ram_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 22,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic [31:0]           fill_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [31:0]           csum_o,
  output state_e                dbg_state_o,
  impl_ram_dma_if.master        ram
);

  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  mode_q, mode_d;
  logic [31:0]           fill_q, fill_d;
  logic                  err_q, err_d;
  logic [31:0]           csum_q, csum_d;
  logic [31:0]           wdata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      mode_q  <= MODE_COPY;
      fill_q  <= '0;
      err_q   <= 1'b0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
      csum_q  <= csum_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    mode_d    = mode_q;
    fill_d    = fill_q;
    err_d     = err_q;
    csum_d    = csum_q;
    wdata     = '0;
    ram.en    = 1'b0;
    ram.we    = 1'b0;
    ram.be    = 4'h0;
    ram.addr  = '0;
    ram.wdata = '0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d  = src_addr_i;
          dst_d  = dst_addr_i;
          rem_d  = len_i;
          mode_d = mode_i;
          fill_d = fill_data_i;
          err_d  = 1'b0;
          csum_d = '0;
          // The source address is irrelevant in fill mode, so only its
          // alignment in copy mode counts as an error.
          if (((mode_i == MODE_COPY) && (src_addr_i[1:0] != 2'b00)) ||
              (dst_addr_i[1:0] != 2'b00)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (len_i == '0) begin
            state_d = DONE;
          end else begin
            state_d = (mode_i == MODE_FILL) ? WR : RD;
          end
        end
      end

      RD: begin
        ram.en   = 1'b1;
        ram.addr = src_q;
        state_d  = WR;
      end

      WR: begin
        // In copy mode the word read in the preceding RD cycle is on rdata
        // now and is forwarded straight to the write port.
        wdata     = (mode_q == MODE_FILL) ? fill_q : ram.rdata;
        ram.en    = 1'b1;
        ram.we    = 1'b1;
        ram.be    = BE_FULL;
        ram.addr  = dst_q;
        ram.wdata = wdata;
        csum_d    = csum_q ^ wdata;
        src_d     = src_q + WORD_STEP;
        dst_d     = dst_q + WORD_STEP;
        rem_d     = rem_q - LEN_WIDTH'(1);
        if (rem_q == LEN_WIDTH'(1)) begin
          state_d = DONE;
        end else begin
          state_d = (mode_q == MODE_FILL) ? WR : RD;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // busy_o covers the cycle in which the start is accepted as well, so it
  // is combinational on start_i while IDLE.
  assign busy_o      = (state_q != IDLE) || (start_i && !rst_i);
  assign done_o      = (state_q == DONE);
  assign err_o       = err_q;
  assign csum_o      = csum_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/impl_ram_dma.md
Name: impl_ram_dma

Overview:
- Initiator-side engine for the dual-port implementation RAM. Drives one RAM port (en/addr/wdata/we/be in, rdata out) to copy or fill word blocks without the core.
- Used by the FPGA test harness to relocate or clear program/data regions after the RAM loads its init file. The core runs on the other RAM port.
- Owns its RAM port exclusively while busy. Read data is assumed valid one cycle after an enabled read (registered, low-latency RAM mode).

Parameters:
- ADDR_WIDTH, 22, byte-address width of the RAM port (matches RAM ADDR_WIDTH).
- LEN_WIDTH, 16, width of the transfer length in 32-bit words.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle request; sampled only in IDLE.
- mode_i  in  1  0 = copy (src→dst), 1 = fill (fill_data_i→dst).
- src_addr_i  in  ADDR_WIDTH  source byte address; must be word aligned.
- dst_addr_i  in  ADDR_WIDTH  destination byte address; must be word aligned.
- len_i  in  LEN_WIDTH  number of 32-bit words to transfer.
- fill_data_i  in  32  fill pattern, captured at start.
- busy_o  out  1  high from the accepted start through the DONE state.
- done_o  out  1  one-cycle pulse at completion or abort.
- err_o  out  1  sticky misalignment error; cleared by the next accepted start.
- csum_o  out  32  XOR of all words written in the last transfer.
- ram_en_o  out  1  RAM port enable.
- ram_addr_o  out  ADDR_WIDTH  RAM byte address, bits [1:0] always 0.
- ram_wdata_o  out  32  RAM write data.
- ram_we_o  out  1  RAM write enable.
- ram_be_o  out  4  RAM byte enables; 4'hF during writes, 4'h0 otherwise.
- ram_rdata_i  in  32  RAM read data, valid one cycle after a read.

Behaviour:
- Reset values (asynchronous, rst_i=1): state IDLE; busy_o=0, done_o=0, err_o=0, csum_o=0, ram_en_o=0, ram_we_o=0, ram_be_o=0, ram_addr_o=0, ram_wdata_o=0. All internal counters and address registers are 0.
- Reset asserted mid-transfer aborts immediately. The RAM port is released in the same cycle and no further writes are issued.
- States: IDLE, RD, WR, DONE.
- IDLE, start_i=1:
  - Captures src, dst, len, mode and fill_data.
  - Clears err_o and csum_o; sets busy_o.
  - If src[1:0]!=0 (copy mode only) or dst[1:0]!=0: set err_o and go to DONE with no RAM access.
  - Else if len_i==0: go to DONE.
  - Else go to RD (copy) or WR (fill).
- start_i outside IDLE is ignored; it is neither queued nor errored.
- RD: ram_en_o=1, ram_we_o=0, ram_be_o=0, ram_addr_o=src. Next state is WR.
- WR:
  - Drives ram_en_o=1, ram_we_o=1, ram_be_o=4'hF, ram_addr_o=dst.
  - ram_wdata_o = ram_rdata_i (copy) or the captured fill data (fill).
  - Same cycle: csum ^= wdata; src += 4; dst += 4; remaining -= 1.
  - If remaining was 1, go to DONE. Otherwise go to RD (copy) or stay in WR (fill).
- Throughput: copy takes 2 cycles/word, fill takes 1 cycle/word. Latency from start to done_o is 2·len+2 cycles for copy and len+2 for fill.
- DONE: done_o=1 for exactly one cycle; RAM outputs are inactive. Next state is IDLE; busy_o falls when entering IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH and wraps silently past the top.
- Copy is strictly ascending. With overlapping regions where dst>src and dst<src+4·len, source words are overwritten before they are read, giving forward propagation of the first words. This is the defined behaviour, not an error.
- Outside RD/WR, ram_en_o=0, ram_we_o=0 and ram_be_o=0.

Decomposition:
- Package impl_ram_dma_pkg holds:
  - the state enum (IDLE, RD, WR, DONE);
  - the mode constants MODE_COPY=1'b0 and MODE_FILL=1'b1;
  - the constant BE_FULL=4'hF.
- No sub-module. The datapath is a single FSM plus address and length counters.

Test Plan:
- Fill: dst=0x100, len=4, fill=0xDEADBEEF → writes at 0x100, 0x104, 0x108, 0x10C on 4 consecutive cycles; done_o at cycle 6; csum_o=0.
- Copy: RAM model preloaded 0x0=0x11111111 and 0x4=0x22222222; src=0, dst=0x200, len=2 → 0x200/0x204 hold those values; done_o at cycle 6; csum_o=0x33333333.
- Misaligned: dst=0x102, len=3 → no ram_en_o; err_o=1; done_o pulse at cycle 2. A following valid start clears err_o.
- len=0 → no RAM access; done_o at cycle 2; busy_o high for 2 cycles.
- Wrap: ADDR_WIDTH=8, fill dst=0xFC, len=2 → writes at 0xFC then 0x00.
- rst_i asserted during the 3rd word of an 8-word copy → outputs return to reset values asynchronously; no further writes; no done_o.
